// File: rtl/max7219_rx.sv
// Receiver for a cascaded MAX7219 serial chain: it samples the driver's clock, data and load
// lines, and on each load rising edge decodes every device's 16-bit word into that device's registers.
module max7219_rx #(
  parameter int DEVICES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    spi_clk,
  input  logic                    spi_din,
  input  logic                    spi_load,
  output logic [DEVICES*64-1:0]   digits,
  output logic [DEVICES*8-1:0]    decode_mode,
  output logic [DEVICES*4-1:0]    intensity,
  output logic [DEVICES*3-1:0]    scan_limit,
  output logic [DEVICES-1:0]      shutdown,
  output logic [DEVICES-1:0]      display_test,
  output logic                    frame_valid,
  output logic                    frame_error
);

  localparam int W = DEVICES * 16;
  localparam logic [7:0] FULL_COUNT = 8'(W);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Index 1 of each chain is the synchronized value; index 2 is the delayed copy used for edge detection.
  logic [2:0] clk_sync;
  logic [2:0] load_sync;
  logic [1:0] din_sync;
  logic       clk_rise;
  logic       load_rise;

  state_t     state;
  logic [7:0] bit_cnt;
  logic [W-1:0] shift_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '0;
      load_sync <= '0;
      din_sync  <= '0;
    end else begin
      clk_sync  <= {clk_sync[1:0], spi_clk};
      load_sync <= {load_sync[1:0], spi_load};
      din_sync  <= {din_sync[0], spi_din};
    end
  end

  assign clk_rise  = clk_sync[1] & ~clk_sync[2];
  assign load_rise = load_sync[1] & ~load_sync[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      digits       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown     <= '1;
      display_test <= '0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE, SHIFT: begin
          // A clock edge arriving with the load edge still belongs to this frame.
          if (clk_rise) begin
            shift_reg <= {shift_reg[W-2:0], din_sync[1]};
            if (bit_cnt != 8'hFF) bit_cnt <= bit_cnt + 8'd1;
          end
          if (load_rise)
            state <= COMMIT;
          else if (clk_rise)
            state <= SHIFT;
        end
        COMMIT: begin
          if (bit_cnt == FULL_COUNT) begin
            for (int d = 0; d < DEVICES; d++) begin
              case (shift_reg[d*16+8 +: 4])
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                  digits[d*64 + (int'(shift_reg[d*16+8 +: 4]) - 1)*8 +: 8] <= shift_reg[d*16 +: 8];
                4'h9: decode_mode[d*8 +: 8] <= shift_reg[d*16 +: 8];
                4'hA: intensity[d*4 +: 4]   <= shift_reg[d*16 +: 4];
                4'hB: scan_limit[d*3 +: 3]  <= shift_reg[d*16 +: 3];
                4'hC: shutdown[d]           <= ~shift_reg[d*16];
                4'hF: display_test[d]       <= shift_reg[d*16];
                default: ;
              endcase
            end
            frame_valid <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
          bit_cnt   <= '0;
          shift_reg <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_rx.sv
// Bench for max7219_rx: table-driven and random frames against a register-level model of the chain.
module tb_max7219_rx;
  localparam int DEV = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_clk = 1'b0, spi_din = 1'b0, spi_load = 1'b0;
  logic [DEV*64-1:0] digits;
  logic [DEV*8-1:0]  decode_mode;
  logic [DEV*4-1:0]  intensity;
  logic [DEV*3-1:0]  scan_limit;
  logic [DEV-1:0]    shutdown, display_test;
  logic              frame_valid, frame_error;

  max7219_rx #(.DEVICES(DEV)) dut (
    .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_din(spi_din), .spi_load(spi_load),
    .digits(digits), .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .shutdown(shutdown), .display_test(display_test),
    .frame_valid(frame_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_digit [DEV][8];
  logic [7:0] m_dec   [DEV];
  logic [3:0] m_int   [DEV];
  logic [2:0] m_scan  [DEV];
  logic       m_shut  [DEV];
  logic       m_test  [DEV];

  typedef struct {
    logic [39:0] frame;
    int          nbits;
    bit          coinc;
    bit          exp_valid;
  } vec_t;

  task automatic tick(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < DEV; d++) begin
      for (int n = 0; n < 8; n++) m_digit[d][n] = 8'h00;
      m_dec[d] = 8'h00; m_int[d] = 4'h0; m_scan[d] = 3'd0; m_shut[d] = 1'b1; m_test[d] = 1'b0;
    end
  endtask

  // Device d takes the d-th 16-bit word counted from the end of the frame.
  task automatic model_commit(input logic [31:0] f);
    for (int d = 0; d < DEV; d++) begin
      logic [15:0] w;
      int a;
      w = f[d*16 +: 16];
      a = int'(w[11:8]);
      if (a >= 1 && a <= 8) m_digit[d][a-1] = w[7:0];
      else if (a == 9)  m_dec[d]  = w[7:0];
      else if (a == 10) m_int[d]  = w[3:0];
      else if (a == 11) m_scan[d] = w[2:0];
      else if (a == 12) m_shut[d] = ~w[0];
      else if (a == 15) m_test[d] = w[0];
    end
  endtask

  task automatic check_regs(input string name);
    logic [DEV*64-1:0] e_dig;
    logic [DEV*8-1:0]  e_dec;
    logic [DEV*4-1:0]  e_int;
    logic [DEV*3-1:0]  e_scan;
    logic [DEV-1:0]    e_shut, e_test;
    for (int d = 0; d < DEV; d++) begin
      for (int n = 0; n < 8; n++) e_dig[d*64 + n*8 +: 8] = m_digit[d][n];
      e_dec[d*8 +: 8] = m_dec[d];
      e_int[d*4 +: 4] = m_int[d];
      e_scan[d*3 +: 3] = m_scan[d];
      e_shut[d] = m_shut[d];
      e_test[d] = m_test[d];
    end
    check({name, ".digits"},       128'(digits),       128'(e_dig));
    check({name, ".decode_mode"},  128'(decode_mode),  128'(e_dec));
    check({name, ".intensity"},    128'(intensity),    128'(e_int));
    check({name, ".scan_limit"},   128'(scan_limit),   128'(e_scan));
    check({name, ".shutdown"},     128'(shutdown),     128'(e_shut));
    check({name, ".display_test"}, 128'(display_test), 128'(e_test));
  endtask

  // Bits go out MSB first, four clk periods per half spi_clk period; with coinc the load
  // line rises together with the final spi_clk rise and both are left high.
  task automatic send_bits(input logic [39:0] f, input int n, input bit coinc);
    for (int i = 0; i < n; i++) begin
      spi_din = f[n-1-i];
      tick(4);
      spi_clk = 1'b1;
      if (coinc && i == n-1) begin
        spi_load = 1'b1;
      end else begin
        tick(4);
        spi_clk = 1'b0;
      end
    end
  endtask

  task automatic do_commit(input string name, input logic [39:0] f, input int n, input bit exp_valid);
    int v_cnt, e_cnt, v_first, e_first;
    v_cnt = 0; e_cnt = 0; v_first = 0; e_first = 0;
    spi_load = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (frame_valid) begin v_cnt++; if (v_first == 0) v_first = e; end
      if (frame_error) begin e_cnt++; if (e_first == 0) e_first = e; end
    end
    spi_clk = 1'b0;
    spi_load = 1'b0;
    tick(4);
    check({name, ".valid_pulses"}, 128'(v_cnt), 128'(exp_valid ? 1 : 0));
    check({name, ".error_pulses"}, 128'(e_cnt), 128'(exp_valid ? 0 : 1));
    check({name, ".latency"}, 128'(exp_valid ? v_first : e_first), 128'(4));
    if (exp_valid) model_commit(f[31:0]);
    check_regs(name);
    $display("frame %-10s bits=%0d data=%h valid=%0d error=%0d edge=%0d",
             name, n, f[31:0], v_cnt, e_cnt, exp_valid ? v_first : e_first);
  endtask

  task automatic apply_reset(input string name);
    reset_n = 1'b0;
    spi_clk = 1'b0; spi_load = 1'b0; spi_din = 1'b0;
    tick(3);
    model_reset();
    check_regs(name);
    check({name, ".pulses"}, 128'({frame_valid, frame_error}), 128'(0));
    reset_n = 1'b1;
    tick(2);
    $display("reset %s", name);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{40'h00_0C01_0355, 32, 1'b0, 1'b1};
    vecs[1] = '{40'h00_0A0F_0B07, 32, 1'b0, 1'b1};
    vecs[2] = '{40'h00_01AA_0234, 31, 1'b0, 1'b0};
    vecs[3] = '{40'h00_01AA_0234, 32, 1'b0, 1'b1};
    vecs[4] = '{40'h00_0000_0D12, 32, 1'b0, 1'b1};
    vecs[5] = '{40'h00_09C3_0866, 32, 1'b1, 1'b1};
    vecs[6] = '{40'h00_0000_0000,  0, 1'b0, 1'b0};
    vecs[7] = '{40'h5A_0F01_0C00, 33, 1'b0, 1'b0};

    apply_reset("power_on");

    for (int i = 0; i < 8; i++) begin
      send_bits(vecs[i].frame, vecs[i].nbits, vecs[i].coinc);
      do_commit($sformatf("tbl%0d", i), vecs[i].frame, vecs[i].nbits, vecs[i].exp_valid);
      if (i == 0) begin
        check("tbl0.shutdown_const", 128'(shutdown), 128'(2'b01));
        check("tbl0.digit2_const", 128'(digits[23:16]), 128'(8'h55));
      end
      if (i == 1) begin
        check("tbl1.intensity_hi", 128'(intensity[7:4]), 128'(4'hF));
        check("tbl1.scan_lo", 128'(scan_limit[2:0]), 128'(3'd7));
      end
    end

    // Partial frame cut off by reset: the stale bits must not count toward the next frame.
    send_bits(40'h00_0F01_0108, 20, 1'b0);
    apply_reset("mid_frame");
    send_bits(40'h0, 0, 1'b0);
    do_commit("post_rst0", 40'h0, 0, 1'b0);
    send_bits(40'h00_0F01_0108, 32, 1'b0);
    do_commit("post_rst1", 40'h00_0F01_0108, 32, 1'b1);
    check("post_rst1.test_const", 128'(display_test), 128'(2'b10));
    check("post_rst1.digit0_const", 128'(digits[7:0]), 128'(8'h08));

    for (int k = 0; k < 24; k++) begin
      logic [39:0] f;
      int n;
      int r;
      bit c;
      f = {8'($urandom), 32'($urandom)};
      r = $urandom_range(0, 9);
      n = (r == 0) ? 31 : (r == 1) ? 33 : 32;
      c = 1'($urandom_range(0, 1));
      send_bits(f, n, c);
      do_commit($sformatf("rnd%0d", k), f, n, n == 32);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/max7219_rx.md
MAX7219_RX -- requirements
Module: max7219_rx

Interface
REQ-001 Parameter DEVICES, default 2: number of cascaded MAX7219 devices emulated in one chain.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 spi_clk  input  1  serial clock from the MAX7219 driver (clk_out); asynchronous to clk.
REQ-005 spi_din  input  1  serial data from the driver (data_out), MSB first.
REQ-006 spi_load  input  1  load/CS from the driver (load_out); a rising edge commits the frame.
REQ-007 digits  output  DEVICES*64  digit registers; device d, digit n (address n+1) at bits [d*64+n*8 +: 8].
REQ-008 decode_mode  output  DEVICES*8  decode-mode register per device, device d at [d*8 +: 8].
REQ-009 intensity  output  DEVICES*4  intensity register per device, device d at [d*4 +: 4].
REQ-010 scan_limit  output  DEVICES*3  scan-limit register per device, device d at [d*3 +: 3].
REQ-011 shutdown  output  DEVICES  1 = device in shutdown (shutdown register D0 = 0).
REQ-012 display_test  output  DEVICES  display-test register D0 per device.
REQ-013 frame_valid  output  1  one-clk pulse when a correctly sized frame is committed.
REQ-014 frame_error  output  1  one-clk pulse when a frame of the wrong length is discarded.

Function
REQ-015 spi_clk, spi_din and spi_load SHALL each pass through a 2-flop synchronizer; edges SHALL be detected from the synchronized values and a third registered copy.
REQ-016 spi_clk SHALL be at most clk/4; behaviour at higher rates is undefined.
REQ-017 On each detected spi_clk rising edge, the synchronized spi_din SHALL shift into the LSB of a DEVICES*16-bit shift register, and the bit counter (8 bits, saturating at 255) SHALL increment.
REQ-018 State machine: IDLE (counter 0) -> SHIFT on the first spi_clk rising edge; SHIFT -> COMMIT on a spi_load rising edge; COMMIT -> IDLE after one cycle. A spi_load rising edge in IDLE is treated as a commit with count 0.
REQ-019 After DEVICES*16 bits, shift bits [d*16 +: 16] SHALL be the word for device d; device 0 receives the last word shifted, device DEVICES-1 the first.
REQ-020 In COMMIT, if count == DEVICES*16, each device word SHALL be decoded (bits [11:8] address, [7:0] data, [15:12] ignored), registers updated, and frame_valid pulsed; otherwise no register changes and frame_error pulsed.
REQ-021 Address decode: 0x0 no-op; 0x1-0x8 digit n=addr-1 <= data; 0x9 decode_mode <= data; 0xA intensity <= data[3:0]; 0xB scan_limit <= data[2:0]; 0xC shutdown <= ~data[0]; 0xF display_test <= data[0]; 0xD, 0xE ignored.
REQ-022 Commit latency: outputs and pulse SHALL update on the 4th clk rising edge, counting the first edge that samples spi_load high as edge 1.
REQ-023 A spi_clk rising edge detected in the same cycle as a spi_load rising edge SHALL be shifted and counted before the length check.
REQ-024 The counter and shift register SHALL clear in COMMIT; spi_load falling edges and spi_clk falling edges SHALL have no effect.
REQ-025 frame_valid and frame_error SHALL never assert in the same cycle and SHALL each be exactly one clk wide.

Reset
REQ-026 While reset_n is low: digits, decode_mode, intensity, scan_limit, display_test = 0; shutdown = all ones; frame_valid, frame_error = 0; counter 0; state IDLE; synchronizers cleared.
REQ-027 A reset asserted mid-frame SHALL discard partial bits; after release, the first spi_load rising edge without 32 following bits (DEVICES=2) SHALL give frame_error.

Verification
REQ-028 Reset, then 32-bit frame 0x0C01_0355, load rise -> shutdown = 2'b01, digits[7:0 of device0 digit 2] i.e. bits [23:16] = 0x55, frame_valid one pulse at edge 4.
REQ-029 Frame 0x0A0F_0B07 -> intensity[7:4] = 0xF, scan_limit[2:0] = 3'd7, all other registers unchanged.
REQ-030 31-bit frame then load -> frame_error pulse, all registers unchanged; next correct frame commits normally.
REQ-031 Frame 0x0000_0D12 (no-op + reserved) -> frame_valid pulses, no register changes.
REQ-032 Reset asserted after 20 bits of frame 0x0F01_0108, released, 32 bits of 0x0F01_0108 sent -> display_test = 2'b10, digits[7:0] = 0x08.
REQ-033 spi_clk edge coincident with spi_load rise on 32nd bit -> frame accepted (frame_valid), value includes that bit.
